video_sync_cleaner: RTL and testbench

//  Upstream stage of the scanline darkener. Takes a core's raw pixel stream and turns it into

---
 rtl/video_pkg.sv | 7 +
 rtl/sync_polarity.sv | 32 +++
 rtl/video_sync_cleaner.sv | 138 +++++++++++++
 tb/tb_video_sync_cleaner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants for the video sync cleaner: pixel width and default geometry/polarity widths.
package video_pkg;
  localparam int unsigned RGB_W      = 24;
  localparam int unsigned HCNT_W_DEF = 12;
  localparam int unsigned VCNT_W_DEF = 11;
  localparam int unsigned POL_W_DEF  = 8;
endpackage

// File: rtl/sync_polarity.sv
// Majority-vote polarity detector for one sync signal: a signed saturating accumulator
// whose sign tells whether the sync spends most of its time high (i.e. is active-low).
module sync_polarity #(
  parameter int unsigned POL_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic raw,
  output logic inv
);
  localparam logic signed [POL_W-1:0] ACC_MAX = {1'b0, {(POL_W-1){1'b1}}};
  localparam logic signed [POL_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [POL_W-1:0] ACC_ONE = 1;

  logic signed [POL_W-1:0] acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (ce) begin
      if (raw) begin
        if (acc != ACC_MAX) acc <= acc + ACC_ONE;
      end else begin
        if (acc != ACC_MIN) acc <= acc - ACC_ONE;
      end
    end
  end

  // Strictly positive means the signal idles high, so its active level is low.
  assign inv = !acc[POL_W-1] && (acc != '0);
endmodule

// File: rtl/video_sync_cleaner.sv
// Cleans a raw core video stream: polarity-normalised syncs, line-aligned de, blanked RGB,
// and line/frame geometry measurement with a two-frame stability flag.
module video_sync_cleaner
  import video_pkg::*;
#(
  parameter int unsigned HCNT_W = HCNT_W_DEF,
  parameter int unsigned VCNT_W = VCNT_W_DEF,
  parameter int unsigned POL_W  = POL_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic              hs_raw,
  input  logic              vs_raw,
  input  logic              hblank,
  input  logic              vblank,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic              ce_out,
  output logic [HCNT_W-1:0] h_total,
  output logic [VCNT_W-1:0] v_total,
  output logic              stable
);
  logic hs_inv, vs_inv;
  logic hs_clean, vs_clean, hs_rise, vs_rise;
  logic hblank_q, vbl_line, de_next;
  logic [HCNT_W-1:0] hcnt, h_total_next, h_total_new, h_prev;
  logic [VCNT_W-1:0] vcnt, vcnt_inc, v_prev;
  logic h_sat, sat_now, sat_seen, sat_frame, stable_next;
  logic [1:0] cap_cnt;

  sync_polarity #(.POL_W(POL_W)) u_hs_pol (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_pix),
    .raw     (hs_raw),
    .inv     (hs_inv)
  );

  sync_polarity #(.POL_W(POL_W)) u_vs_pol (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_pix),
    .raw     (vs_raw),
    .inv     (vs_inv)
  );

  // The registered sync outputs double as the previous cleaned sample for edge detection.
  always_comb begin
    hs_clean = hs_raw ^ hs_inv;
    vs_clean = vs_raw ^ vs_inv;
    hs_rise  = hs_clean & ~hs_out;
    vs_rise  = vs_clean & ~vs_out;
    de_next  = ~(hblank | vbl_line);
  end

  // A coincident hs rise is folded into the line count before v_total is captured.
  always_comb begin
    h_sat        = &hcnt;
    h_total_next = h_sat ? '1 : hcnt + HCNT_W'(1);
    h_total_new  = hs_rise ? h_total_next : h_total;
    vcnt_inc     = vcnt;
    if (hs_rise && !(&vcnt)) vcnt_inc = vcnt + VCNT_W'(1);
    sat_now      = h_sat | (&vcnt_inc);
    sat_frame    = sat_seen | sat_now;
    stable_next  = (h_total_new == h_prev) && (vcnt_inc == v_prev) &&
                   !sat_frame && (cap_cnt == 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_out <= 1'b0;
    end else begin
      ce_out <= ce_pix;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out  <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      de_out   <= 1'b0;
      hblank_q <= 1'b0;
      vbl_line <= 1'b0;
    end else if (ce_pix) begin
      rgb_out  <= de_next ? rgb_in : '0;
      hs_out   <= hs_clean;
      vs_out   <= vs_clean;
      de_out   <= de_next;
      hblank_q <= hblank;
      if (hblank && !hblank_q) vbl_line <= vblank;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt    <= '0;
      h_total <= '0;
    end else if (ce_pix) begin
      if (hs_rise) begin
        h_total <= h_total_next;
        hcnt    <= '0;
      end else if (!h_sat) begin
        hcnt    <= hcnt + HCNT_W'(1);
      end
    end
  end

  // cap_cnt gates stable until two captures exist, so a partial post-reset frame never counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcnt     <= '0;
      v_total  <= '0;
      h_prev   <= '0;
      v_prev   <= '0;
      stable   <= 1'b0;
      cap_cnt  <= '0;
      sat_seen <= 1'b0;
    end else if (ce_pix) begin
      if (vs_rise) begin
        v_total  <= vcnt_inc;
        vcnt     <= '0;
        h_prev   <= h_total_new;
        v_prev   <= vcnt_inc;
        stable   <= stable_next;
        sat_seen <= 1'b0;
        if (cap_cnt != 2'd2) cap_cnt <= cap_cnt + 2'd1;
      end else begin
        vcnt     <= vcnt_inc;
        sat_seen <= sat_frame;
      end
    end
  end
endmodule

// File: tb/tb_video_sync_cleaner.sv
// Directed bench for video_sync_cleaner: a vector table for ce/de/rgb timing plus
// generated lines and frames for polarity, geometry, stability and async reset.
module tb_video_sync_cleaner;
  import video_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ce_pix = 1'b0;
  logic [RGB_W-1:0]  rgb_in = '0;
  logic              hs_raw = 1'b0;
  logic              vs_raw = 1'b0;
  logic              hblank = 1'b0;
  logic              vblank = 1'b0;
  logic [RGB_W-1:0]  rgb_out;
  logic              hs_out, vs_out, de_out, ce_out, stable;
  logic [11:0]       h_total;
  logic [10:0]       v_total;

  video_sync_cleaner #(.HCNT_W(12), .VCNT_W(11), .POL_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .rgb_in  (rgb_in),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .hblank  (hblank),
    .vblank  (vblank),
    .rgb_out (rgb_out),
    .hs_out  (hs_out),
    .vs_out  (vs_out),
    .de_out  (de_out),
    .ce_out  (ce_out),
    .h_total (h_total),
    .v_total (v_total),
    .stable  (stable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int s_stable, s_h, s_v;

  typedef struct {
    logic        ce;
    logic        hb;
    logic        vb;
    logic [23:0] rgb;
    logic [23:0] exp_rgb;
    logic        exp_de;
    logic        exp_ce;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk: drive on the falling edge, return just after the next rising edge.
  task automatic tick(input logic ce, input logic [23:0] rgb, input logic hs, input logic vs,
                      input logic hb, input logic vb);
    @(negedge clk);
    ce_pix = ce; rgb_in = rgb; hs_raw = hs; vs_raw = vs; hblank = hb; vblank = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ce_pix = 1'b0; rgb_in = '0; hs_raw = 1'b0; vs_raw = 1'b0; hblank = 1'b0; vblank = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame of nlines lines, len ce each; hs pulse at line start, vs high for line 0.
  task automatic run_frame(input int nlines, input int len, input int hsw, input int hbw,
                           input bit inv, input bit vb_on, input int chk_line, input string tag);
    int hs_e, de_e, rgb_e, g;
    logic hs, vs, hb, vb, vbl, de_exp;
    logic [23:0] rgb;
    hs_e = 0; de_e = 0; rgb_e = 0;
    for (int line = 0; line < nlines; line++) begin
      for (int pos = 0; pos < len; pos++) begin
        g   = line * len + pos;
        hs  = (pos < hsw) ^ inv;
        vs  = (line == 0);
        hb  = (pos < hbw);
        vb  = vb_on && ((g < 20 * len + 8) || (g >= (nlines - 10) * len + 8));
        rgb = (hb || vb) ? 24'hFFFFFF : {line[7:0], pos[7:0], 8'h5A};
        tick(1'b1, rgb, hs, vs, hb, vb);
        if (g == 0) begin
          s_stable = 32'(stable);
          s_h      = 32'(h_total);
          s_v      = 32'(v_total);
        end
        if (chk_line >= 0 && line >= chk_line) begin
          vbl    = vb_on && ((line <= 20) || (line >= nlines - 9));
          de_exp = (pos >= hbw) && !vbl;
          if (hs_out !== (pos < hsw)) hs_e++;
          if (de_out !== de_exp) de_e++;
          if (rgb_out !== (de_exp ? rgb : 24'h0)) rgb_e++;
        end
      end
    end
    if (chk_line >= 0) begin
      check({tag, "_hs_errs"}, 32'(hs_e), 32'd0);
      check({tag, "_de_errs"}, 32'(de_e), 32'd0);
      check({tag, "_rgb_errs"}, 32'(rgb_e), 32'd0);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'h123456, 24'h123456, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 24'hABCDEF, 24'h123456, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 24'h111111, 24'h123456, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h999999, 24'h123456, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 24'h222222, 24'h222222, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 24'h333333, 24'h000000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 24'h444444, 24'h000000, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h555555, 24'h000000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 24'h666666, 24'h666666, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 24'h777777, 24'h666666, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 24'h888888, 24'h888888, 1'b1, 1'b1};

    do_reset();
    check("rst_rgb", 32'(rgb_out), 32'd0);
    check("rst_de", 32'(de_out), 32'd0);
    check("rst_hs", 32'(hs_out), 32'd0);
    check("rst_vs", 32'(vs_out), 32'd0);
    check("rst_h_total", 32'(h_total), 32'd0);
    check("rst_v_total", 32'(v_total), 32'd0);
    check("rst_stable", 32'(stable), 32'd0);

    // Sparse ce, blanking and mid-line vblank edges.
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].ce, tbl[i].rgb, 1'b0, 1'b0, tbl[i].hb, tbl[i].vb);
      check($sformatf("tbl%0d_rgb", i), 32'(rgb_out), 32'(tbl[i].exp_rgb));
      check($sformatf("tbl%0d_de", i), 32'(de_out), 32'(tbl[i].exp_de));
      check($sformatf("tbl%0d_ce_out", i), 32'(ce_out), 32'(tbl[i].exp_ce));
    end

    // Active-high hs, then inverted hs, 800-ce lines.
    do_reset();
    run_frame(3, 800, 40, 160, 1'b0, 1'b0, 2, "hs_pos");
    check("hs_pos_h_total", 32'(h_total), 32'd800);
    do_reset();
    run_frame(3, 800, 40, 160, 1'b1, 1'b0, 2, "hs_neg");
    check("hs_neg_h_total", 32'(h_total), 32'd800);

    // 525-line frames with mid-line vblank edges.
    do_reset();
    idle(200);
    run_frame(525, 16, 2, 4, 1'b0, 1'b1, -1, "f1");
    check("f1_stable", 32'(s_stable), 32'd0);
    run_frame(525, 16, 2, 4, 1'b0, 1'b1, 0, "f2");
    check("f2_v_total", 32'(s_v), 32'd525);
    check("f2_h_total", 32'(s_h), 32'd16);
    check("f2_stable", 32'(s_stable), 32'd0);
    run_frame(1, 16, 2, 4, 1'b0, 1'b0, -1, "f3");
    check("f3_stable", 32'(s_stable), 32'd1);
    check("f3_v_total", 32'(s_v), 32'd525);

    // Asynchronous reset mid-line: outputs must clear before any further clk edge.
    check("pre_rst_de", 32'(de_out), 32'd1);
    check("pre_rst_ce_out", 32'(ce_out), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_rgb", 32'(rgb_out), 32'd0);
    check("arst_de", 32'(de_out), 32'd0);
    check("arst_ce_out", 32'(ce_out), 32'd0);
    check("arst_h_total", 32'(h_total), 32'd0);
    check("arst_v_total", 32'(v_total), 32'd0);
    check("arst_stable", 32'(stable), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Small frames after reset, then one frame of longer lines.
    idle(200);
    run_frame(10, 16, 2, 4, 1'b0, 1'b0, -1, "s1");
    check("s1_stable", 32'(s_stable), 32'd0);
    run_frame(10, 16, 2, 4, 1'b0, 1'b0, -1, "s2");
    check("s2_stable", 32'(s_stable), 32'd0);
    check("s2_v_total", 32'(s_v), 32'd10);
    run_frame(10, 17, 2, 4, 1'b0, 1'b0, -1, "s3");
    check("s3_stable", 32'(s_stable), 32'd1);
    run_frame(10, 17, 2, 4, 1'b0, 1'b0, -1, "s4");
    check("s4_stable", 32'(s_stable), 32'd0);
    check("s4_h_total", 32'(s_h), 32'd17);
    run_frame(1, 17, 2, 4, 1'b0, 1'b0, -1, "s5");
    check("s5_stable", 32'(s_stable), 32'd1);
    check("s5_h_total", 32'(s_h), 32'd17);
    check("s5_v_total", 32'(s_v), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
